// File: rtl/int_ctrl.sv
// int_ctrl: prioritised interrupt controller for a pipelined core.
//
// Ports
//   Clk        in   clock; all state changes on the rising edge
//   Rst        in   asynchronous reset, active low
//   Irq        in   [N_CH]  level interrupt lines, synchronous to Clk
//   MaskWe     in   mask register write enable
//   MaskIn     in   [N_CH]  new mask value (1 = channel masked)
//   IntAck     in   fetch has taken the outstanding request
//   Rti        in   one-cycle pulse when an RTI retires
//   IntReq     out  interrupt request to the fetch stage
//   Vector     out  [VEC_W] handler vector of the requested channel
//   Pending    out  [N_CH]  latched rising edges not yet acknowledged
//   InService  out  [N_CH]  channels whose handlers are running
//
// Channel 0 has the highest priority. Pending bits latch on rising Irq
// edges regardless of the mask; the mask only affects eligibility.
module int_ctrl #(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned VEC_W    = 16,
  parameter int unsigned VEC_BASE = 0,
  parameter int unsigned NEST     = 0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [N_CH-1:0]  Irq,
  input  logic             MaskWe,
  input  logic [N_CH-1:0]  MaskIn,
  input  logic             IntAck,
  input  logic             Rti,
  output logic             IntReq,
  output logic [VEC_W-1:0] Vector,
  output logic [N_CH-1:0]  Pending,
  output logic [N_CH-1:0]  InService
);

  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic {ST_IDLE, ST_REQ} state_t;

  state_t             r_state;
  logic [N_CH-1:0]    r_irq_d;
  logic [N_CH-1:0]    r_mask;
  logic [N_CH-1:0]    r_pend;
  logic [N_CH-1:0]    r_ins;
  logic [CH_W-1:0]    r_ch;
  logic [VEC_W-1:0]   r_vec;
  logic               r_req;

  logic [N_CH-1:0]    w_edge;
  logic [N_CH-1:0]    w_elig;
  logic               w_win_vld;
  logic [CH_W-1:0]    w_win_idx;
  logic               w_ins_vld;
  logic [CH_W-1:0]    w_ins_idx;
  logic               w_gate;
  logic               w_ack;
  logic [N_CH-1:0]    w_ch_oh;
  logic [N_CH-1:0]    w_pend_nxt;
  logic [N_CH-1:0]    w_ins_set;
  logic [N_CH-1:0]    w_ins_low;
  logic [N_CH-1:0]    w_ins_nxt;
  logic [VEC_W-1:0]   w_vec;

  assign w_edge = Irq & ~r_irq_d;
  assign w_elig = r_pend & ~r_mask;

  // Scanning from the top down leaves the lowest set index in the result.
  always_comb begin
    w_win_vld = 1'b0;
    w_win_idx = '0;
    w_ins_vld = 1'b0;
    w_ins_idx = '0;
    for (int unsigned i = N_CH; i > 0; i--) begin
      if (w_elig[i-1]) begin
        w_win_vld = 1'b1;
        w_win_idx = CH_W'(i - 1);
      end
      if (r_ins[i-1]) begin
        w_ins_vld = 1'b1;
        w_ins_idx = CH_W'(i - 1);
      end
    end
  end

  always_comb begin
    w_gate = 1'b0;
    if (NEST != 0)
      w_gate = w_win_vld && (!w_ins_vld || (w_win_idx < w_ins_idx));
    else
      w_gate = w_win_vld && !w_ins_vld;
  end

  assign w_ack = (r_state == ST_REQ) && IntAck;

  always_comb begin
    w_ch_oh = '0;
    for (int unsigned i = 0; i < N_CH; i++)
      w_ch_oh[i] = w_ack && (r_ch == CH_W'(i));
  end

  // A fresh edge on the acknowledged channel re-arms its pending bit.
  assign w_pend_nxt = (r_pend & ~w_ch_oh) | w_edge;

  // Acknowledge sets first; Rti then retires the highest-priority active
  // handler of that updated set (x & -x isolates the lowest set bit).
  assign w_ins_set = r_ins | w_ch_oh;
  assign w_ins_low = w_ins_set & (~w_ins_set + N_CH'(1));
  assign w_ins_nxt = Rti ? (w_ins_set & ~w_ins_low) : w_ins_set;

  assign w_vec = VEC_W'(VEC_BASE) + VEC_W'(w_win_idx);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= ST_IDLE;
      r_irq_d <= '0;
      r_mask  <= '0;
      r_pend  <= '0;
      r_ins   <= '0;
      r_ch    <= '0;
      r_vec   <= '0;
      r_req   <= 1'b0;
    end else begin
      r_irq_d <= Irq;
      if (MaskWe)
        r_mask <= MaskIn;
      r_pend <= w_pend_nxt;
      r_ins  <= w_ins_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_gate) begin
            r_state <= ST_REQ;
            r_ch    <= w_win_idx;
            r_vec   <= w_vec;
            r_req   <= 1'b1;
          end
        end
        ST_REQ: begin
          if (IntAck) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign IntReq    = r_req;
  assign Vector    = r_vec;
  assign Pending   = r_pend;
  assign InService = r_ins;

endmodule

// File: tb/tb_int_ctrl.sv
// Testbench for int_ctrl. Three instances share one stimulus stream:
//   0: NEST=0, VEC_BASE=0   1: NEST=1, VEC_BASE=0   2: NEST=0, VEC_BASE=FFFE
// A reference model per instance produces expected per-cycle state and
// expected request vectors into queues; a monitor pops and compares.
module tb_int_ctrl;

  localparam int NI = 3;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic [3:0] Irq = '0;
  logic       MaskWe = 1'b0;
  logic [3:0] MaskIn = '0;
  logic       IntAck = 1'b0;
  logic       Rti = 1'b0;

  logic        o_req [NI];
  logic [15:0] o_vec [NI];
  logic [3:0]  o_pend[NI];
  logic [3:0]  o_ins [NI];

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  int_ctrl #(.N_CH(4), .VEC_W(16), .VEC_BASE(0), .NEST(0)) u_dut0 (
    .Clk(Clk), .Rst(Rst), .Irq(Irq), .MaskWe(MaskWe), .MaskIn(MaskIn),
    .IntAck(IntAck), .Rti(Rti), .IntReq(o_req[0]), .Vector(o_vec[0]),
    .Pending(o_pend[0]), .InService(o_ins[0]));

  int_ctrl #(.N_CH(4), .VEC_W(16), .VEC_BASE(0), .NEST(1)) u_dut1 (
    .Clk(Clk), .Rst(Rst), .Irq(Irq), .MaskWe(MaskWe), .MaskIn(MaskIn),
    .IntAck(IntAck), .Rti(Rti), .IntReq(o_req[1]), .Vector(o_vec[1]),
    .Pending(o_pend[1]), .InService(o_ins[1]));

  int_ctrl #(.N_CH(4), .VEC_W(16), .VEC_BASE(32'hFFFE), .NEST(0)) u_dut2 (
    .Clk(Clk), .Rst(Rst), .Irq(Irq), .MaskWe(MaskWe), .MaskIn(MaskIn),
    .IntAck(IntAck), .Rti(Rti), .IntReq(o_req[2]), .Vector(o_vec[2]),
    .Pending(o_pend[2]), .InService(o_ins[2]));

  typedef struct {
    logic [3:0]  p;
    logic [3:0]  s;
    logic        r;
    logic [15:0] v;
  } exp_t;

  exp_t        st_q[NI][$];
  logic [15:0] vq  [NI][$];

  int nest_of[NI] = '{0, 1, 0};
  int base_of[NI] = '{0, 0, 32'hFFFE};

  // Model state: plain bit sets plus "which channel is being requested".
  logic [3:0]  m_pend[NI];
  logic [3:0]  m_ins [NI];
  logic [3:0]  m_mask[NI];
  logic [3:0]  m_irqd[NI];
  bit          m_busy[NI];
  int          m_ch  [NI];
  logic [15:0] m_vec [NI];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset(input int k);
    m_pend[k] = '0; m_ins[k] = '0; m_mask[k] = '0; m_irqd[k] = '0;
    m_busy[k] = 0;  m_ch[k] = 0;   m_vec[k] = '0;
  endtask

  task automatic model_step(input int k, input logic [3:0] irq, input logic mwe,
                            input logic [3:0] min, input logic ack, input logic rti);
    int w = -1;
    int l = 4;
    bit go;
    logic [3:0] np, ns;
    for (int i = 0; i < 4; i++) begin
      if (w < 0 && m_pend[k][i] && !m_mask[k][i]) w = i;
      if (l == 4 && m_ins[k][i]) l = i;
    end
    if (nest_of[k] != 0) go = (w >= 0) && (w < l);
    else                 go = (w >= 0) && (m_ins[k] == 0);
    np = m_pend[k];
    ns = m_ins[k];
    if (m_busy[k]) begin
      if (ack) begin
        np[m_ch[k]] = 1'b0;
        ns[m_ch[k]] = 1'b1;
        m_busy[k] = 0;
      end
    end else if (go) begin
      m_busy[k] = 1;
      m_ch[k]   = w;
      m_vec[k]  = 16'((base_of[k] + w) % 65536);
      vq[k].push_back(m_vec[k]);
    end
    np = np | (irq & ~m_irqd[k]);
    if (rti) begin
      for (int i = 0; i < 4; i++)
        if (ns[i]) begin
          ns[i] = 1'b0;
          break;
        end
    end
    m_pend[k] = np;
    m_ins[k]  = ns;
    if (mwe) m_mask[k] = min;
    m_irqd[k] = irq;
  endtask

  // One clock: drive at the falling edge, advance models, push expectations,
  // return at the next falling edge.
  task automatic cyc(input logic [3:0] irq, input logic mwe, input logic [3:0] min,
                     input logic ack, input logic rti, input logic rst);
    exp_t e;
    Irq = irq; MaskWe = mwe; MaskIn = min; IntAck = ack; Rti = rti; Rst = rst;
    for (int k = 0; k < NI; k++) begin
      if (!rst) model_reset(k);
      else      model_step(k, irq, mwe, min, ack, rti);
      e.p = m_pend[k]; e.s = m_ins[k]; e.r = m_busy[k]; e.v = m_vec[k];
      st_q[k].push_back(e);
    end
    if (!rst) begin
      #1;
      for (int k = 0; k < NI; k++) begin
        chk($sformatf("rst_req[%0d]", k),  o_req[k],  0);
        chk($sformatf("rst_vec[%0d]", k),  o_vec[k],  0);
        chk($sformatf("rst_pend[%0d]", k), o_pend[k], 0);
        chk($sformatf("rst_ins[%0d]", k),  o_ins[k],  0);
      end
    end
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic idle(input logic [3:0] irq);
    cyc(irq, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic ack_c(input logic [3:0] irq);
    cyc(irq, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic rti_c(input logic [3:0] irq);
    cyc(irq, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);
  endtask

  // Monitor: compares per-cycle state and each new request's vector.
  initial begin : monitor
    bit   prev_req[NI];
    exp_t e;
    logic [15:0] ev;
    for (int k = 0; k < NI; k++) prev_req[k] = 0;
    forever begin
      @(posedge Clk);
      #1;
      for (int k = 0; k < NI; k++) begin
        if (st_q[k].size() > 0) begin
          e = st_q[k].pop_front();
          chk($sformatf("pend[%0d]", k), o_pend[k], e.p);
          chk($sformatf("ins[%0d]", k),  o_ins[k],  e.s);
          chk($sformatf("req[%0d]", k),  o_req[k],  e.r);
          if (e.r) chk($sformatf("hold_vec[%0d]", k), o_vec[k], e.v);
        end
        if (o_req[k] && !prev_req[k]) begin
          if (vq[k].size() == 0) begin
            chk($sformatf("unexpected_req[%0d]", k), 1, 0);
          end else begin
            ev = vq[k].pop_front();
            chk($sformatf("req_vec[%0d]", k), o_vec[k], ev);
          end
        end
        prev_req[k] = o_req[k];
      end
    end
  end

  logic [3:0] r_irq;

  initial begin : driver
    for (int k = 0; k < NI; k++) model_reset(k);
    @(negedge Clk);
    cyc(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    idle(4'b0000);

    // Single edge on channel 2
    idle(4'b0100);
    chk("d1_pend", o_pend[0], 4'b0100);
    chk("d1_req0", o_req[0], 0);
    idle(4'b0000);
    chk("d1_req1", o_req[0], 1);
    chk("d1_vec",  o_vec[0], 2);
    ack_c(4'b0000);
    chk("d1_pend_ack", o_pend[0], 4'b0000);
    chk("d1_ins_ack",  o_ins[0],  4'b0100);
    rti_c(4'b0000);
    idle(4'b0000);

    // Simultaneous edges on 1 and 3; ch3 also exercises the vector wrap
    idle(4'b1010);
    idle(4'b0000);
    chk("d2_vec_first", o_vec[0], 1);
    ack_c(4'b0000);
    idle(4'b0000);
    chk("d2_blocked", o_req[0], 0);
    rti_c(4'b0000);
    idle(4'b0000);
    chk("d2_req_second", o_req[0], 1);
    chk("d2_vec_second", o_vec[0], 3);
    chk("d2_vec_wrap",   o_vec[2], 16'h0001);
    ack_c(4'b0000);
    rti_c(4'b0000);
    idle(4'b0000);

    // Masked channel latches pending but stays quiet until unmasked
    cyc(4'b0000, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b1);
    idle(4'b0010);
    chk("d3_pend", o_pend[0], 4'b0010);
    idle(4'b0000);
    idle(4'b0000);
    chk("d3_masked", o_req[0], 0);
    cyc(4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1);
    idle(4'b0000);
    chk("d3_unmasked", o_req[0], 1);
    chk("d3_vec", o_vec[0], 1);
    ack_c(4'b0000);
    rti_c(4'b0000);
    idle(4'b0000);

    // Nesting: channel 2 in service, then channel 0 arrives
    idle(4'b0100);
    idle(4'b0000);
    ack_c(4'b0000);
    idle(4'b0001);
    idle(4'b0000);
    chk("d4_nonest_req", o_req[0], 0);
    chk("d4_nest_req",   o_req[1], 1);
    chk("d4_nest_vec",   o_vec[1], 0);
    ack_c(4'b0000);
    chk("d4_nest_ins", o_ins[1], 4'b0101);
    chk("d4_nonest_still", o_req[0], 0);
    rti_c(4'b0000);
    idle(4'b0000);
    chk("d4_nonest_after_rti", o_req[0], 1);
    chk("d4_nonest_vec", o_vec[0], 0);
    ack_c(4'b0000);
    rti_c(4'b0000);
    idle(4'b0000);

    // Reset during REQ, Irq[0] held high across release
    idle(4'b0100);
    idle(4'b0000);
    chk("d5_in_req", o_req[0], 1);
    cyc(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    cyc(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    idle(4'b0001);
    chk("d5_rel_pend", o_pend[0], 4'b0001);
    chk("d5_rel_req",  o_req[0], 0);
    idle(4'b0001);
    chk("d5_req", o_req[0], 1);
    chk("d5_vec", o_vec[0], 0);
    ack_c(4'b0001);
    rti_c(4'b0001);
    idle(4'b0000);

    // Randomised traffic
    r_irq = '0;
    for (int n = 0; n < 3000; n++) begin
      logic mwe, ack, rti, rst;
      logic [3:0] min;
      r_irq = r_irq ^ (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
      mwe = ($urandom_range(0, 15) == 0);
      min = 4'($urandom) & 4'($urandom);
      ack = ($urandom_range(0, 1) == 1);
      rti = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 399) != 0);
      cyc(r_irq, mwe, min, ack, rti, rst);
    end

    idle(4'b0000);
    idle(4'b0000);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("vq_left[%0d]", k), vq[k].size(), 0);
      chk($sformatf("stq_left[%0d]", k), st_q[k].size(), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
